// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request bus between the CPU MEM stage and the data memory.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    modport master(output req, we, addr, wdata, input ack, rdata, err, busy);
    modport slave(input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering each request after LATENCY wait cycles.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input logic CLK,
    input logic Reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH];
    logic          bad;
    logic          resp;
    logic [AW-1:0] idx;
    assign resp      = state == RESP;
    // No wrapping: anything past the last word is an error, whatever the high bits.
    assign bad       = (cap_addr[1:0] != 2'b00) || (cap_addr >= 32'(4 * DEPTH));
    assign idx       = cap_addr[AW+1:2];
    assign bus.ack   = resp;
    assign bus.err   = resp && bad;
    assign bus.rdata = (resp && !cap_we && !bad) ? mem[idx] : '0;
    assign bus.busy  = state != IDLE;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (state == IDLE) begin
            if (bus.req) begin
                cap_we    <= bus.we;
                cap_addr  <= bus.addr;
                cap_wdata <= bus.wdata;
                cnt       <= 4'(LATENCY);
                state     <= (LATENCY > 0) ? WAIT : RESP;
            end
        end else if (state == WAIT) begin
            cnt   <= cnt - 4'd1;
            state <= (cnt == 4'd1) ? RESP : WAIT;
        end else begin
            state <= IDLE;
        end
    end
    // Stores commit on the edge leaving RESP, so a reset in WAIT drops them.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (resp && cap_we && !bad) begin
            mem[idx] <= cap_wdata;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized checks of two responders (LATENCY 2 and 0) against an array model.
module tb_data_mem_responder;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] m0 [64];
    logic [31:0] m1 [64];
    data_mem_responder_if a ();
    data_mem_responder_if b ();
    data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut0 (.CLK(CLK), .Reset(Reset), .bus(a.slave));
    data_mem_responder #(.DEPTH(64), .LATENCY(0)) dut1 (.CLK(CLK), .Reset(Reset), .bus(b.slave));
    always #5 CLK = ~CLK;

    function automatic bit is_err(input logic [31:0] ad);
        return (ad % 4 != 0) || (ad >= 32'd256);
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 64; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
    endtask

    task automatic access(input bit sel, input bit w, input logic [31:0] ad, input logic [31:0] wd, input string tag);
        int lat;
        int want_lat;
        bit exp_err;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic got_err;
        want_lat = sel ? 1 : 3;
        exp_err = is_err(ad);
        exp_rd = (w || exp_err) ? 32'd0 : (sel ? m1[ad/4] : m0[ad/4]);
        @(negedge CLK);
        a.we = w; a.addr = ad; a.wdata = wd;
        b.we = w; b.addr = ad; b.wdata = wd;
        if (sel) b.req = 1'b1; else a.req = 1'b1;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (lat == 1) begin
                n_checks++;
                if ((sel ? b.busy : a.busy) !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy after capture: got %b want 1", tag, sel ? b.busy : a.busy);
                end
            end
        end while (!(sel ? b.ack : a.ack) && lat < 40);
        got_rd = sel ? b.rdata : a.rdata;
        got_err = sel ? b.err : a.err;
        a.req = 1'b0;
        b.req = 1'b0;
        n_checks++;
        if (lat !== want_lat) begin
            n_fail++;
            $display("FAIL %s ack latency: got %0d edges want %0d", tag, lat, want_lat);
        end
        n_checks++;
        if (got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", tag, got_err, exp_err);
        end
        n_checks++;
        if (got_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", tag, got_rd, exp_rd);
        end
        if (w && !exp_err) begin
            if (sel) m1[ad/4] = wd; else m0[ad/4] = wd;
        end
        @(posedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({a.ack, a.err, a.busy, a.rdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got ack=%b err=%b busy=%b rdata=%h want all 0", a.ack, a.err, a.busy, a.rdata);
        end
        clear_models();
        @(negedge CLK);
        Reset = 1'b0;
        access(0, 0, 32'h0, 32'h0, "load0_after_reset");
    endtask

    task automatic test_store_load();
        access(0, 1, 32'h8, 32'h12345678, "store_8");
        access(0, 0, 32'h8, 32'h0, "load_8");
        n_checks++;
        if (m0[2] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL model_store_8: got %h want 12345678", m0[2]);
        end
    endtask

    task automatic test_errors();
        access(0, 1, 32'h6, 32'hDEADBEEF, "store_misaligned_6");
        access(0, 0, 32'h4, 32'h0, "load_4_untouched");
        access(0, 0, 32'h100, 32'h0, "load_100_range");
        access(0, 0, 32'hFC, 32'h0, "load_fc_last");
        access(0, 1, 32'h8000_0010, 32'h55, "store_high_nowrap");
        access(0, 0, 32'h10, 32'h0, "load_10_nowrap");
    endtask

    task automatic test_reset_in_wait();
        access(0, 1, 32'h10, 32'h0BADF00D, "store_10_pre");
        @(negedge CLK);
        a.we = 1'b1; a.addr = 32'h10; a.wdata = 32'hAAAA5555; a.req = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (a.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_busy: got %b want 1", a.busy);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (a.busy !== 1'b0 || a.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got busy=%b ack=%b want 0 0", a.busy, a.ack);
        end
        a.req = 1'b0;
        clear_models();
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (a.ack !== 1'b0) begin
                n_fail++;
                $display("FAIL dropped_ack: got %b want 0", a.ack);
            end
        end
        access(0, 0, 32'h10, 32'h0, "load_10_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] ad;
        int k;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 5);
            ad = (k == 0) ? {$urandom_range(0, 63), 2'b00} + 32'($urandom_range(1, 3)) :
                 (k == 1) ? 32'd256 + 32'($urandom_range(0, 4096)) * 4 :
                 32'({$urandom_range(0, 7), 2'b00});
            access(0, 1'($urandom_range(0, 1)), ad, $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        logic [31:0] cur;
        access(1, 1, 32'h0, 32'hCAFE0000, "b_store_0");
        access(1, 1, 32'h4, 32'h0000BEEF, "b_store_4");
        cur = 32'h0;
        acks = 0;
        @(negedge CLK);
        b.we = 1'b0; b.addr = cur; b.req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (b.ack !== 1'(k % 2)) begin
                n_fail++;
                $display("FAIL b2b ack edge %0d: got %b want %b", k, b.ack, 1'(k % 2));
            end
            if (b.ack === 1'b1) begin
                acks++;
                n_checks++;
                if (b.rdata !== m1[cur/4]) begin
                    n_fail++;
                    $display("FAIL b2b rdata addr %h: got %h want %h", cur, b.rdata, m1[cur/4]);
                end
                cur = cur ^ 32'h4;
                b.addr = cur;
            end
        end
        b.req = 1'b0;
        n_checks++;
        if (acks !== 6) begin
            n_fail++;
            $display("FAIL b2b ack count: got %0d want 6", acks);
        end
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        a.req = 1'b0; a.we = 1'b0; a.addr = '0; a.wdata = '0;
        b.req = 1'b0; b.we = 1'b0; b.addr = '0; b.wdata = '0;
        clear_models();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        test_reset();
        test_store_load();
        test_errors();
        test_reset_in_wait();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
